// File: rtl/l15_req_arbiter.sv
// Arbitrates two L1.5 caches onto one L2 msg1 channel and routes msg2 back.
// Optional WAIT-state watchdog enabled by defining CCP_ARB_TIMEOUT_EN.
`ifndef MSG_TYPE_EMPTY
`define MSG_TYPE_EMPTY 0
`endif
`ifndef MSG_TYPE_DATA_ACK
`define MSG_TYPE_DATA_ACK 36
`endif

module l15_req_arbiter #(
  parameter int MSG_WIDTH  = 8,
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_WIDTH = 64,
  parameter int MESI_WIDTH = 2
`ifdef CCP_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 7
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MSG_WIDTH-1:0]  c0_msg1_type,
  input  logic [TAG_WIDTH-1:0]  c0_msg1_tag,
  input  logic [DATA_WIDTH-1:0] c0_msg1_data,
  input  logic [MSG_WIDTH-1:0]  c1_msg1_type,
  input  logic [TAG_WIDTH-1:0]  c1_msg1_tag,
  input  logic [DATA_WIDTH-1:0] c1_msg1_data,
  output logic [MSG_WIDTH-1:0]  l2_msg1_type,
  output logic [TAG_WIDTH-1:0]  l2_msg1_tag,
  output logic [DATA_WIDTH-1:0] l2_msg1_data,
  input  logic [MSG_WIDTH-1:0]  l2_msg2_type,
  input  logic [TAG_WIDTH-1:0]  l2_msg2_tag,
  input  logic [DATA_WIDTH-1:0] l2_msg2_data,
  input  logic [MESI_WIDTH-1:0] l2_mesi_send,
  input  logic                  l2_msg2_dst,
  output logic [MSG_WIDTH-1:0]  c0_msg2_type,
  output logic [TAG_WIDTH-1:0]  c0_msg2_tag,
  output logic [DATA_WIDTH-1:0] c0_msg2_data,
  output logic [MESI_WIDTH-1:0] c0_mesi_send,
  output logic [MSG_WIDTH-1:0]  c1_msg2_type,
  output logic [TAG_WIDTH-1:0]  c1_msg2_tag,
  output logic [DATA_WIDTH-1:0] c1_msg2_data,
  output logic [MESI_WIDTH-1:0] c1_mesi_send,
  output logic                  owner,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam logic [MSG_WIDTH-1:0] LP_EMPTY =
    MSG_WIDTH'(`MSG_TYPE_EMPTY);
  localparam logic [MSG_WIDTH-1:0] LP_DACK =
    MSG_WIDTH'(`MSG_TYPE_DATA_ACK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner;
  logic                  r_last;
  logic [MSG_WIDTH-1:0]  r_msg1_type;
  logic [TAG_WIDTH-1:0]  r_msg1_tag;
  logic [DATA_WIDTH-1:0] r_msg1_data;

  logic w_c0_pend;
  logic w_c1_pend;
  logic w_any;
  logic w_sel;
  logic w_owner_ack;
  logic w_timeout;

  assign w_c0_pend = (c0_msg1_type != LP_EMPTY);
  assign w_c1_pend = (c1_msg1_type != LP_EMPTY);
  assign w_any     = w_c0_pend | w_c1_pend;
  // On a tie the cache that was not granted last wins.
  assign w_sel     = w_c1_pend & (~w_c0_pend | ~r_last);

  assign w_owner_ack = (l2_msg2_type == LP_DACK) &&
                       (l2_msg2_dst == r_owner);

`ifdef CCP_ARB_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_tmo;

  assign w_timeout = (r_state == S_WAIT) &&
                     (r_cnt == CNT_WIDTH'(TIMEOUT - 1)) &&
                     !w_owner_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt + 1'b1;
      if (w_timeout)
        r_tmo <= 1'b1;
    end
  end

  assign timeout_err = r_tmo;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_any) w_next = S_ISSUE;
      S_ISSUE:
        w_next = w_owner_ack ? S_IDLE : S_WAIT;
      S_WAIT:
        if (w_owner_ack || w_timeout) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_msg1_type <= LP_EMPTY;
      r_msg1_tag  <= '0;
      r_msg1_data <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (w_any) begin
            r_owner     <= w_sel;
            r_last      <= w_sel;
            r_msg1_type <= w_sel ? c1_msg1_type : c0_msg1_type;
            r_msg1_tag  <= w_sel ? c1_msg1_tag  : c0_msg1_tag;
            r_msg1_data <= w_sel ? c1_msg1_data : c0_msg1_data;
          end
        S_ISSUE: begin
          r_msg1_type <= LP_EMPTY;
          r_msg1_tag  <= '0;
          r_msg1_data <= '0;
        end
        default: ;
      endcase
    end
  end

  assign owner        = r_owner;
  assign l2_msg1_type = r_msg1_type;
  assign l2_msg1_tag  = r_msg1_tag;
  assign l2_msg1_data = r_msg1_data;

  // msg2 routing is purely combinational and ignores state and reset.
  assign c0_msg2_type = l2_msg2_dst ? LP_EMPTY : l2_msg2_type;
  assign c0_msg2_tag  = l2_msg2_dst ? '0 : l2_msg2_tag;
  assign c0_msg2_data = l2_msg2_dst ? '0 : l2_msg2_data;
  assign c0_mesi_send = l2_msg2_dst ? '0 : l2_mesi_send;
  assign c1_msg2_type = l2_msg2_dst ? l2_msg2_type : LP_EMPTY;
  assign c1_msg2_tag  = l2_msg2_dst ? l2_msg2_tag : '0;
  assign c1_msg2_data = l2_msg2_dst ? l2_msg2_data : '0;
  assign c1_mesi_send = l2_msg2_dst ? l2_mesi_send : '0;

endmodule
